// File: rtl/rx_mailbox_controller.sv
`default_nettype none
// ============================================================================
// Module      : rx_mailbox_controller
// Description : Receive-side packet controller. Accepts header+payload packets
//               from the interconnect RX port, stores the payload in a
//               per-source mailbox and pulses a flag-set write for that
//               source. CPU flag clears are snooped into a local occupancy
//               mirror so a full mailbox is never overwritten.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_mailbox_controller #(
  parameter int ADDR_WIDTH_RF = 1,
  parameter int DATA_WIDTH    = 32,
  parameter int PAYLOAD_WORDS = 4,
  localparam int c_idx_w      = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rx_valid,
  input  logic                     rx_sop,
  input  logic [DATA_WIDTH-1:0]    rx_data,
  output logic                     rx_ready,
  input  logic                     rtr_write_enable,
  input  logic [ADDR_WIDTH_RF-1:0] address_2,
  output logic                     rx_write_enable,
  output logic [ADDR_WIDTH_RF-1:0] address_1,
  input  logic [ADDR_WIDTH_RF-1:0] mb_rd_addr,
  input  logic [c_idx_w-1:0]       mb_rd_word,
  output logic [DATA_WIDTH-1:0]    mb_rd_data,
  output logic [7:0]               err_count
);

  localparam int                 c_num_mb   = 2 ** ADDR_WIDTH_RF;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(PAYLOAD_WORDS - 1);
  localparam logic [c_idx_w:0]   c_words    = (c_idx_w + 1)'(PAYLOAD_WORDS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLD    = 2'd1,
    S_PAYLOAD = 2'd2,
    S_COMMIT  = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [ADDR_WIDTH_RF-1:0] r_src;
  logic [c_idx_w-1:0]       r_idx;
  logic [7:0]               r_err;
  logic [ADDR_WIDTH_RF-1:0] r_addr1;
  logic [c_num_mb-1:0]      r_occ;
  logic [DATA_WIDTH-1:0]    r_mem [c_num_mb][PAYLOAD_WORDS];

  logic w_xfer;
  logic w_take_hdr;
  logic w_wr_word;
  logic w_err_inc;

  assign w_xfer    = rx_valid & rx_ready;
  assign address_1 = r_addr1;
  assign err_count = r_err;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus handshake/flag outputs; ready is masked by reset
  // so nothing is accepted while the block is held in reset
  always_comb begin
    w_next          = r_state;
    w_take_hdr      = 1'b0;
    w_wr_word       = 1'b0;
    w_err_inc       = 1'b0;
    rx_ready        = 1'b0;
    rx_write_enable = 1'b0;
    case (r_state)
      S_IDLE: begin
        rx_ready = reset_n;
        if (w_xfer) begin
          if (rx_sop) begin
            w_take_hdr = 1'b1;
            w_next     = S_HOLD;
          end else begin
            w_err_inc = 1'b1;
          end
        end
      end
      S_HOLD: begin
        // Wait until the CPU has drained this source's mailbox
        if (!r_occ[r_src]) begin
          w_next = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        rx_ready = reset_n;
        if (w_xfer) begin
          if (rx_sop) begin
            // Header mid-payload: abandon the current packet, start the new one
            w_err_inc  = 1'b1;
            w_take_hdr = 1'b1;
            w_next     = S_HOLD;
          end else begin
            w_wr_word = 1'b1;
            if (r_idx == c_last_idx) begin
              w_next = S_COMMIT;
            end
          end
        end
      end
      S_COMMIT: begin
        rx_write_enable = 1'b1;
        w_next          = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Packet bookkeeping, error counter and occupancy mirror
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src   <= '0;
      r_idx   <= '0;
      r_err   <= '0;
      r_addr1 <= '0;
      r_occ   <= '0;
    end else begin
      if (w_take_hdr) begin
        r_src <= rx_data[ADDR_WIDTH_RF-1:0];
        r_idx <= '0;
      end else if (w_wr_word) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_err_inc && (r_err != 8'hFF)) begin
        r_err <= r_err + 8'd1;
      end
      // address_1 is loaded on entry to COMMIT and held afterwards
      if (w_next == S_COMMIT) begin
        r_addr1 <= r_src;
      end
      if (r_state == S_COMMIT) begin
        r_occ[r_src] <= 1'b1;
      end
      // Clear is written last so it wins over a same-cycle set on that address
      if (rtr_write_enable) begin
        r_occ[address_2] <= 1'b0;
      end
    end
  end

  // Mailbox storage (not reset; validity is conveyed by the flag)
  always_ff @(posedge clk) begin
    if (w_wr_word) begin
      r_mem[r_src][r_idx] <= rx_data;
    end
  end

  // CPU read port; word selects beyond the payload length read as zero
  always_comb begin
    mb_rd_data = '0;
    if ({1'b0, mb_rd_word} < c_words) begin
      mb_rd_data = r_mem[mb_rd_addr][mb_rd_word];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_mailbox_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rx_mailbox_controller
// Description : Self-checking bench for rx_mailbox_controller. A packet-level
//               reference model runs every cycle alongside directed scenario
//               tasks and a randomized traffic phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_mailbox_controller;

  localparam int AW  = 1;
  localparam int DW  = 32;
  localparam int PW  = 4;
  localparam int IW  = 2;
  localparam int NMB = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic          rx_sop = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_ready;
  logic          rtr_write_enable = 1'b0;
  logic [AW-1:0] address_2 = '0;
  logic          rx_write_enable;
  logic [AW-1:0] address_1;
  logic [AW-1:0] mb_rd_addr = '0;
  logic [IW-1:0] mb_rd_word = '0;
  logic [DW-1:0] mb_rd_data;
  logic [7:0]    err_count;

  rx_mailbox_controller #(
    .ADDR_WIDTH_RF(AW),
    .DATA_WIDTH   (DW),
    .PAYLOAD_WORDS(PW)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rx_valid        (rx_valid),
    .rx_sop          (rx_sop),
    .rx_data         (rx_data),
    .rx_ready        (rx_ready),
    .rtr_write_enable(rtr_write_enable),
    .address_2       (address_2),
    .rx_write_enable (rx_write_enable),
    .address_1       (address_1),
    .mb_rd_addr      (mb_rd_addr),
    .mb_rd_word      (mb_rd_word),
    .mb_rd_data      (mb_rd_data),
    .err_count       (err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- packet-level reference model ----------------
  bit          m_in_pkt, m_gate, m_hdr_new, m_pulse;
  int          m_src, m_words, m_pulse_src, m_addr1, m_err;
  bit [NMB-1:0] m_occ, m_occ_prev, occ_nxt;
  logic [DW-1:0] m_mb [NMB][PW];
  bit          m_mbv [NMB][PW];
  bit          e_rdy, n_pulse, n_hdr;

  // Compares every cycle against the model, then advances it by one clock
  always @(negedge clk) begin
    if (!reset_n) begin
      m_in_pkt = 0; m_gate = 0; m_hdr_new = 0; m_pulse = 0;
      m_src = 0; m_words = 0; m_pulse_src = 0; m_addr1 = 0; m_err = 0;
      m_occ = '0; m_occ_prev = '0;
    end else begin
      // Ready: never in the pulse cycle; after a header, one bubble and then
      // only once the mailbox was seen free in the previous cycle
      if (m_pulse) e_rdy = 0;
      else if (m_gate) begin
        if (m_hdr_new) e_rdy = 0;
        else if (!m_occ_prev[m_src]) begin e_rdy = 1; m_gate = 0; end
        else e_rdy = 0;
      end else e_rdy = 1;

      n_vec++;
      if (rx_ready !== e_rdy) begin
        n_bad++; $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, rx_ready, e_rdy);
      end
      n_vec++;
      if (rx_write_enable !== m_pulse) begin
        n_bad++; $display("FAIL wen cyc=%0d got=%b exp=%b", cyc, rx_write_enable, m_pulse);
      end
      n_vec++;
      if (address_1 !== AW'(m_addr1)) begin
        n_bad++; $display("FAIL addr1 cyc=%0d got=%0d exp=%0d", cyc, address_1, m_addr1);
      end
      n_vec++;
      if (err_count !== 8'(m_err)) begin
        n_bad++; $display("FAIL errcnt cyc=%0d got=%0d exp=%0d", cyc, err_count, m_err);
      end
      if (m_mbv[mb_rd_addr][mb_rd_word]) begin
        n_vec++;
        if (mb_rd_data !== m_mb[mb_rd_addr][mb_rd_word]) begin
          n_bad++; $display("FAIL mbdata cyc=%0d mb[%0d][%0d] got=%h exp=%h", cyc, mb_rd_addr,
                            mb_rd_word, mb_rd_data, m_mb[mb_rd_addr][mb_rd_word]);
        end
      end

      occ_nxt = m_occ;
      if (m_pulse) occ_nxt[m_pulse_src] = 1'b1;
      if (rtr_write_enable) occ_nxt[address_2] = 1'b0;

      n_pulse = 0; n_hdr = 0;
      if (rx_valid && e_rdy) begin
        if (rx_sop) begin
          if (m_in_pkt && m_err < 255) m_err++;
          m_in_pkt = 1; m_src = int'(rx_data[AW-1:0]); m_words = 0; m_gate = 1; n_hdr = 1;
        end else if (!m_in_pkt) begin
          if (m_err < 255) m_err++;
        end else begin
          m_mb[m_src][m_words] = rx_data;
          m_mbv[m_src][m_words] = 1;
          m_words++;
          if (m_words == PW) begin
            n_pulse = 1; m_pulse_src = m_src; m_addr1 = m_src; m_in_pkt = 0;
          end
        end
      end
      m_pulse = n_pulse; m_hdr_new = n_hdr;
      m_occ_prev = m_occ; m_occ = occ_nxt;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_word(input bit sop, input logic [DW-1:0] data, output int acc);
    bit done = 0;
    rx_valid = 1; rx_sop = sop; rx_data = data; acc = -1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (rx_ready) begin acc = cyc; done = 1; end
      @(posedge clk); #1;
    end
    rx_valid = 0; rx_sop = 0;
    if (!done) begin
      n_vec++; n_bad++;
      $display("FAIL send_timeout data=%h got=no_ready exp=accepted", data);
    end
  endtask

  task automatic rtr_pulse(input int a);
    rtr_write_enable = 1; address_2 = AW'(a);
    @(posedge clk); #1;
    rtr_write_enable = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got=%b exp=0", rx_ready); end
    n_vec++; if (rx_write_enable !== 1'b0) begin n_bad++; $display("FAIL rst_wen got=%b exp=0", rx_write_enable); end
    n_vec++; if (address_1 !== '0) begin n_bad++; $display("FAIL rst_addr1 got=%0d exp=0", address_1); end
    n_vec++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL rst_err got=%0d exp=0", err_count); end
    reset_n = 1;
    @(negedge clk);
    n_vec++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready got=%b exp=1", rx_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_packet;
    int th, t0, t;
    send_word(1, 32'h0000_0001, th);
    send_word(0, 32'hA0, t0);
    for (int i = 1; i < PW; i++) send_word(0, DW'(32'hA0 + i), t);
    n_vec++; if (t0 - th != 2) begin n_bad++; $display("FAIL first_payload_lat got=%0d exp=2", t0 - th); end
    n_vec++; if (t - th != 5) begin n_bad++; $display("FAIL back_to_back got=%0d exp=5", t - th); end
    @(negedge clk);
    n_vec++; if (rx_write_enable !== 1'b1 || address_1 !== 1'b1) begin
      n_bad++; $display("FAIL commit1 got=%b/%0d exp=1/1", rx_write_enable, address_1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after got=%b exp=1", rx_ready); end
    for (int i = 0; i < PW; i++) begin
      mb_rd_addr = 1; mb_rd_word = IW'(i); #1;
      n_vec++;
      if (mb_rd_data !== DW'(32'hA0 + i)) begin
        n_bad++; $display("FAIL mb1_word%0d got=%h exp=%h", i, mb_rd_data, 32'hA0 + i);
      end
    end
    n_vec++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL err_pkt1 got=%0d exp=0", err_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_occupied_hold;
    int th, t;
    send_word(1, 32'h1, th);
    rx_valid = 1; rx_sop = 0; rx_data = 32'hB0;
    repeat (5) begin
      @(negedge clk);
      n_vec++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL hold_ready got=%b exp=0", rx_ready); end
      @(posedge clk); #1;
    end
    rtr_write_enable = 1; address_2 = 1;
    @(negedge clk);
    n_vec++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL clr_c0 got=%b exp=0", rx_ready); end
    @(posedge clk); #1;
    rtr_write_enable = 0;
    @(negedge clk);
    n_vec++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL clr_c1 got=%b exp=0", rx_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL clr_c2 got=%b exp=1", rx_ready); end
    @(posedge clk); #1;
    rx_valid = 0;
    for (int i = 1; i < PW; i++) send_word(0, DW'(32'hB0 + i), t);
    @(negedge clk);
    n_vec++; if (rx_write_enable !== 1'b1 || address_1 !== 1'b1) begin
      n_bad++; $display("FAIL commit2 got=%b/%0d exp=1/1", rx_write_enable, address_1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_errors;
    int t;
    send_word(0, 32'hDEAD, t);
    @(negedge clk);
    n_vec++; if (err_count !== 8'd1) begin n_bad++; $display("FAIL stray_err got=%0d exp=1", err_count); end
    @(posedge clk); #1;
    send_word(1, 32'h10, t);
    send_word(0, 32'hC0, t);
    send_word(0, 32'hC1, t);
    send_word(1, 32'h20, t);
    @(negedge clk);
    n_vec++; if (err_count !== 8'd2 || rx_write_enable !== 1'b0) begin
      n_bad++; $display("FAIL abort got=%0d/%b exp=2/0", err_count, rx_write_enable);
    end
    @(posedge clk); #1;
    for (int i = 0; i < PW; i++) send_word(0, DW'(32'hD0 + i), t);
    @(negedge clk);
    n_vec++; if (rx_write_enable !== 1'b1 || address_1 !== 1'b0) begin
      n_bad++; $display("FAIL commit_after_abort got=%b/%0d exp=1/0", rx_write_enable, address_1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_commit_clear_collision;
    int th, t0, t;
    rtr_pulse(0);
    send_word(1, 32'h0, th);
    for (int i = 0; i < PW; i++) send_word(0, DW'(32'hE0 + i), t);
    rtr_write_enable = 1; address_2 = 0;
    @(negedge clk);
    n_vec++; if (rx_write_enable !== 1'b1 || address_1 !== 1'b0) begin
      n_bad++; $display("FAIL collide_commit got=%b/%0d exp=1/0", rx_write_enable, address_1);
    end
    @(posedge clk); #1;
    rtr_write_enable = 0;
    send_word(1, 32'h0, th);
    send_word(0, 32'hF0, t0);
    n_vec++; if (t0 - th != 2) begin n_bad++; $display("FAIL not_held got=%0d exp=2", t0 - th); end
    for (int i = 1; i < PW; i++) send_word(0, DW'(32'hF0 + i), t);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_packet;
    int th, t0, t;
    rtr_pulse(1);
    send_word(1, 32'h1, th);
    send_word(0, 32'h55, t);
    send_word(0, 32'h56, t);
    reset_n = 0; #1;
    n_vec++; if (rx_ready !== 1'b0 || rx_write_enable !== 1'b0 || address_1 !== '0 || err_count !== 8'd0) begin
      n_bad++; $display("FAIL async_reset got=%b/%b/%0d/%0d exp=0/0/0/0", rx_ready, rx_write_enable,
                        address_1, err_count);
    end
    repeat (2) @(posedge clk);
    #1; reset_n = 1;
    send_word(1, 32'h0, th);
    send_word(0, 32'h70, t0);
    n_vec++; if (t0 - th != 2) begin n_bad++; $display("FAIL occ_cleared got=%0d exp=2", t0 - th); end
    for (int i = 1; i < PW; i++) send_word(0, DW'(32'h70 + i), t);
    @(negedge clk);
    n_vec++; if (rx_write_enable !== 1'b1 || address_1 !== 1'b0) begin
      n_bad++; $display("FAIL fresh_commit got=%b/%0d exp=1/0", rx_write_enable, address_1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    for (int i = 0; i < 800; i++) begin
      rx_valid         = ($urandom_range(0, 9) < 8);
      rx_sop           = ($urandom_range(0, 7) == 0);
      rx_data          = $urandom;
      rtr_write_enable = ($urandom_range(0, 4) == 0);
      address_2        = AW'($urandom_range(0, NMB - 1));
      mb_rd_addr       = AW'($urandom_range(0, NMB - 1));
      mb_rd_word       = IW'($urandom_range(0, PW - 1));
      @(posedge clk); #1;
    end
    rx_valid = 0; rx_sop = 0; rtr_write_enable = 0;
  endtask

  task automatic test_saturation;
    reset_n = 0;
    @(posedge clk); #1;
    reset_n = 1;
    rx_valid = 1; rx_sop = 0;
    for (int i = 0; i < 300; i++) begin
      rx_data = $urandom;
      @(posedge clk); #1;
    end
    rx_valid = 0;
    @(negedge clk);
    n_vec++; if (err_count !== 8'd255) begin n_bad++; $display("FAIL sat got=%0d exp=255", err_count); end
    @(posedge clk); #1;
    rx_valid = 1;
    repeat (20) begin @(posedge clk); #1; end
    rx_valid = 0;
    @(negedge clk);
    n_vec++; if (err_count !== 8'd255) begin n_bad++; $display("FAIL sat_hold got=%0d exp=255", err_count); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_occupied_hold();
    test_errors();
    test_commit_clear_collision();
    test_reset_mid_packet();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
